// File: rtl/sandhi_fuser.sv
// rtl/sandhi_fuser.sv - holds one decoded instruction and fuses LUI+ADDI / ADDI+LOAD pairs into macro-ops
module sandhi_fuser #(
  parameter int OPCODE_WIDTH = 7,
  parameter int REG_WIDTH    = 5,
  parameter int IMM_WIDTH    = 12,
  parameter int HOLD_TIMEOUT = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] in_dhatu,
  input  logic [2:0]              in_pratyaya,
  input  logic [REG_WIDTH-1:0]    in_karta,
  input  logic [REG_WIDTH-1:0]    in_karma,
  input  logic [REG_WIDTH-1:0]    in_karana,
  input  logic [IMM_WIDTH-1:0]    in_upasarga,
  input  logic [3:0]              in_instr_type,
  input  logic                    in_sandhi_possible,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OPCODE_WIDTH-1:0] out_dhatu,
  output logic [2:0]              out_pratyaya,
  output logic [REG_WIDTH-1:0]    out_karta,
  output logic [REG_WIDTH-1:0]    out_karma,
  output logic [REG_WIDTH-1:0]    out_karana,
  output logic [31:0]             out_imm,
  output logic [3:0]              out_instr_type,
  output logic                    out_fused,
  output logic [1:0]              out_kind,
  output logic [CNT_WIDTH-1:0]    fused_count
);

  localparam int TW = (HOLD_TIMEOUT < 2) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI  = OPCODE_WIDTH'(7'b0110111);
  localparam logic [OPCODE_WIDTH-1:0] OP_IMM  = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD = OPCODE_WIDTH'(7'b0000011);
  localparam logic [3:0]              TYPE_SANDHI = 4'd6;

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_DRAIN} state_t;

  state_t                  state;
  logic [TW-1:0]           timer;
  logic [OPCODE_WIDTH-1:0] h_dhatu;
  logic [2:0]              h_pratyaya;
  logic [REG_WIDTH-1:0]    h_karta, h_karma, h_karana;
  logic [IMM_WIDTH-1:0]    h_upasarga;
  logic [3:0]              h_type;

  logic o_free, h_valid, xfer, timeout, rule1, rule2, fuse_now, o_load;
  state_t entry_state;
  logic [31:0] h_imm, in_sext, h_sext;

  logic [OPCODE_WIDTH-1:0] n_dhatu;
  logic [2:0]              n_pratyaya;
  logic [REG_WIDTH-1:0]    n_karta, n_karma, n_karana;
  logic [31:0]             n_imm;
  logic [3:0]              n_type;
  logic [1:0]              n_kind;

  assign o_free      = !out_valid || out_ready;
  assign h_valid     = (state != S_EMPTY);
  assign in_ready    = !flush && (!h_valid || o_free);
  assign xfer        = in_valid && in_ready;
  assign timeout     = (timer == TW'(HOLD_TIMEOUT));
  assign entry_state = (in_sandhi_possible && (HOLD_TIMEOUT > 0)) ? S_WAIT : S_DRAIN;

  assign in_sext = {{(32-IMM_WIDTH){in_upasarga[IMM_WIDTH-1]}}, in_upasarga};
  assign h_sext  = {{(32-IMM_WIDTH){h_upasarga[IMM_WIDTH-1]}}, h_upasarga};
  assign h_imm   = (h_dhatu == OP_LUI) ? 32'({h_upasarga, h_karma, h_pratyaya, 12'b0}) : h_sext;

  // Both rules need the successor to read and write the candidate's destination, which must not be x0
  assign rule1 = (h_dhatu == OP_LUI) && (in_dhatu == OP_IMM) && (in_pratyaya == 3'b000) &&
                 (in_karma == h_karta) && (in_karta == h_karta) && (h_karta != '0);
  assign rule2 = (h_dhatu == OP_IMM) && (h_pratyaya == 3'b000) && (in_dhatu == OP_LOAD) &&
                 (in_karma == h_karta) && (in_karta == h_karta) && (h_karta != '0);

  assign fuse_now = (state == S_WAIT) && xfer && (rule1 || rule2);
  assign o_load   = !flush && (((state == S_DRAIN) && o_free) ||
                               ((state == S_WAIT) && xfer) ||
                               ((state == S_WAIT) && !xfer && timeout && o_free));

  // Macro-op presented to the output register: the held op as-is, or the fused pair
  always_comb begin
    n_dhatu    = h_dhatu;
    n_pratyaya = h_pratyaya;
    n_karta    = h_karta;
    n_karma    = h_karma;
    n_karana   = h_karana;
    n_imm      = h_imm;
    n_type     = h_type;
    n_kind     = 2'd0;
    if (fuse_now && rule1) begin
      n_pratyaya = 3'b000;
      n_karma    = '0;
      n_karana   = '0;
      n_imm      = h_imm + in_sext;
      n_type     = TYPE_SANDHI;
      n_kind     = 2'd1;
    end else if (fuse_now) begin
      n_dhatu    = OP_LOAD;
      n_pratyaya = in_pratyaya;
      n_karta    = in_karta;
      n_karana   = '0;
      n_imm      = h_sext + in_sext;
      n_type     = TYPE_SANDHI;
      n_kind     = 2'd2;
    end
  end

  // Hold-register FSM: accepts new entries, waits on candidates until successor or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      timer      <= '0;
      h_dhatu    <= '0;
      h_pratyaya <= '0;
      h_karta    <= '0;
      h_karma    <= '0;
      h_karana   <= '0;
      h_upasarga <= '0;
      h_type     <= '0;
    end else if (flush) begin
      state <= S_EMPTY;
      timer <= '0;
    end else begin
      if (xfer) begin
        h_dhatu    <= in_dhatu;
        h_pratyaya <= in_pratyaya;
        h_karta    <= in_karta;
        h_karma    <= in_karma;
        h_karana   <= in_karana;
        h_upasarga <= in_upasarga;
        h_type     <= in_instr_type;
      end
      timer <= '0;
      case (state)
        S_EMPTY: if (xfer) state <= entry_state;
        S_DRAIN: if (o_free) state <= xfer ? entry_state : S_EMPTY;
        S_WAIT: begin
          if (xfer) begin
            state <= fuse_now ? S_EMPTY : entry_state;
          end else if (timeout && o_free) begin
            state <= S_EMPTY;
          end else begin
            timer <= timeout ? timer : timer + 1'b1;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Output register and saturating fusion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_dhatu      <= '0;
      out_pratyaya   <= '0;
      out_karta      <= '0;
      out_karma      <= '0;
      out_karana     <= '0;
      out_imm        <= '0;
      out_instr_type <= '0;
      out_fused      <= 1'b0;
      out_kind       <= '0;
      fused_count    <= '0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      out_dhatu      <= '0;
      out_pratyaya   <= '0;
      out_karta      <= '0;
      out_karma      <= '0;
      out_karana     <= '0;
      out_imm        <= '0;
      out_instr_type <= '0;
      out_fused      <= 1'b0;
      out_kind       <= '0;
    end else if (o_load) begin
      out_valid      <= 1'b1;
      out_dhatu      <= n_dhatu;
      out_pratyaya   <= n_pratyaya;
      out_karta      <= n_karta;
      out_karma      <= n_karma;
      out_karana     <= n_karana;
      out_imm        <= n_imm;
      out_instr_type <= n_type;
      out_fused      <= fuse_now;
      out_kind       <= n_kind;
      if (fuse_now && (fused_count != '1)) fused_count <= fused_count + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sandhi_fuser.sv
// tb/tb_sandhi_fuser.sv - scoreboard bench for sandhi_fuser
module tb_sandhi_fuser;

  localparam logic [6:0] LUI = 7'b0110111, OPI = 7'b0010011, LD = 7'b0000011, OPR = 7'b0110011;

  typedef struct packed {
    logic [6:0] d; logic [2:0] p; logic [4:0] kt, km, kn;
    logic [11:0] u; logic [3:0] t; logic sp;
  } in_t;

  typedef struct packed {
    logic [6:0] d; logic [2:0] p; logic [4:0] kt, km, kn;
    logic [3:0] t; logic f; logic [1:0] k; logic [31:0] imm;
  } exp_t;

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1;
  logic [6:0] in_dhatu = '0, out_dhatu;
  logic [2:0] in_pratyaya = '0, out_pratyaya;
  logic [4:0] in_karta = '0, in_karma = '0, in_karana = '0;
  logic [4:0] out_karta, out_karma, out_karana;
  logic [11:0] in_upasarga = '0;
  logic [3:0] in_instr_type = '0, out_instr_type;
  logic in_sandhi_possible = 0, out_fused;
  logic [31:0] out_imm;
  logic [1:0] out_kind;
  logic [15:0] fused_count;

  int passed = 0, total = 0;
  exp_t q[$];

  sandhi_fuser dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dhatu(in_dhatu), .in_pratyaya(in_pratyaya), .in_karta(in_karta),
    .in_karma(in_karma), .in_karana(in_karana), .in_upasarga(in_upasarga),
    .in_instr_type(in_instr_type), .in_sandhi_possible(in_sandhi_possible),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_dhatu(out_dhatu), .out_pratyaya(out_pratyaya), .out_karta(out_karta),
    .out_karma(out_karma), .out_karana(out_karana), .out_imm(out_imm),
    .out_instr_type(out_instr_type), .out_fused(out_fused), .out_kind(out_kind),
    .fused_count(fused_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    if (obs === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic in_t lui(input logic [4:0] rd, input logic [19:0] v);
    return '{d:LUI, p:v[2:0], kt:rd, km:v[7:3], kn:5'd0, u:v[19:8], t:4'd1, sp:1'b1};
  endfunction
  function automatic in_t addi(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] i);
    return '{d:OPI, p:3'b000, kt:rd, km:rs, kn:5'd0, u:i, t:4'd2, sp:1'b1};
  endfunction
  function automatic in_t lw(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] i);
    return '{d:LD, p:3'b010, kt:rd, km:rs, kn:5'd0, u:i, t:4'd3, sp:1'b1};
  endfunction
  function automatic in_t add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [11:0] i);
    return '{d:OPR, p:3'b000, kt:rd, km:rs1, kn:rs2, u:i, t:4'd4, sp:1'b0};
  endfunction
  function automatic exp_t plain(input in_t o, input logic [31:0] imm);
    return '{d:o.d, p:o.p, kt:o.kt, km:o.km, kn:o.kn, t:o.t, f:1'b0, k:2'd0, imm:imm};
  endfunction

  // Scoreboard: every accepted output handshake pops and compares the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) check("unexpected_op", 64'(out_imm), 64'hDEAD_0000_0000_0000);
      else begin
        exp_t e;
        e = q.pop_front();
        check("op_fields", 64'({out_dhatu, out_pratyaya, out_karta, out_karma, out_karana,
                                out_instr_type, out_fused, out_kind}),
              64'({e.d, e.p, e.kt, e.km, e.kn, e.t, e.f, e.k}));
        check("op_imm", 64'(out_imm), 64'(e.imm));
      end
    end
  end

  task automatic drive(input in_t o);
    in_dhatu = o.d; in_pratyaya = o.p; in_karta = o.kt; in_karma = o.km;
    in_karana = o.kn; in_upasarga = o.u; in_instr_type = o.t;
    in_sandhi_possible = o.sp; in_valid = 1;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin check("accept_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send(input in_t o);
    drive(o);
    wait_accept();
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    check(tag, 64'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    in_t a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 0);
    check("reset_fused_count", 64'(fused_count), 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;

    // LUI+ADDI fusion
    q.push_back('{d:LUI, p:0, kt:5, km:0, kn:0, t:6, f:1, k:1, imm:32'h12345678});
    send(lui(5, 20'h12345)); send(addi(5, 5, 12'h678));
    wait_empty("drain_fuse1");
    check("count_after_fuse1", 64'(fused_count), 1);

    // Negative ADDI immediate is sign-extended before adding
    q.push_back('{d:LUI, p:0, kt:5, km:0, kn:0, t:6, f:1, k:1, imm:32'h12344FFF});
    send(lui(5, 20'h12345)); send(addi(5, 5, 12'hFFF));
    wait_empty("drain_fuse_neg");
    check("count_after_fuse_neg", 64'(fused_count), 2);

    // Destination mismatch: two plain ops in order
    q.push_back(plain(lui(5, 20'h12345), 32'h12345000));
    q.push_back(plain(addi(6, 5, 12'h001), 32'h00000001));
    send(lui(5, 20'h12345)); send(addi(6, 5, 12'h001));
    wait_empty("drain_nofuse");
    check("count_after_nofuse", 64'(fused_count), 2);

    // ADDI+LOAD fusion
    q.push_back('{d:LD, p:3'b010, kt:7, km:2, kn:0, t:6, f:1, k:2, imm:32'd24});
    send(addi(7, 2, 12'd16)); send(lw(7, 7, 12'd8));
    wait_empty("drain_fuse2");
    check("count_after_fuse2", 64'(fused_count), 3);

    // x0 destination never fuses
    q.push_back(plain(lui(0, 20'h00001), 32'h00001000));
    q.push_back(plain(addi(0, 0, 12'h001), 32'h00000001));
    send(lui(0, 20'h00001)); send(addi(0, 0, 12'h001));
    wait_empty("drain_x0");
    check("count_after_x0", 64'(fused_count), 3);

    // Lone candidate is held for the idle timeout, then released unfused
    q.push_back(plain(lui(5, 20'hABCDE), 32'hABCDE000));
    send(lui(5, 20'hABCDE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lone_held", 64'(out_valid), 0);
    end
    @(posedge clk); #1;
    wait_empty("drain_lone");

    // Consumer stall: input back-pressured, order kept
    out_ready = 0;
    q.push_back(plain(add(1, 2, 3, 12'h800), 32'hFFFFF800));
    q.push_back(plain(add(4, 5, 6, 12'h000), 32'h00000000));
    q.push_back(plain(add(8, 9, 10, 12'h7FF), 32'h000007FF));
    send(add(1, 2, 3, 12'h800)); send(add(4, 5, 6, 12'h000));
    drive(add(8, 9, 10, 12'h7FF));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 0);
    end
    @(posedge clk); #1 out_ready = 1;
    wait_accept();
    wait_empty("drain_stall");

    // Flush while a LUI waits: dropped, same-cycle input refused
    send(lui(5, 20'h11111));
    flush = 1; drive(add(2, 3, 4, 12'h000));
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 0);
    @(posedge clk); #1 flush = 0; in_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_out_valid", 64'(out_valid), 0);
    end
    @(posedge clk); #1;
    a = add(2, 3, 4, 12'h005);
    q.push_back(plain(a, 32'h00000005));
    send(a);
    wait_empty("drain_after_flush");
    check("count_after_flush", 64'(fused_count), 3);

    // Reset pulse while a LUI is held
    send(lui(5, 20'h22222));
    rst_n = 0;
    @(negedge clk);
    check("midreset_out_valid", 64'(out_valid), 0);
    check("midreset_count", 64'(fused_count), 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("midreset_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    a = add(3, 1, 2, 12'h010);
    q.push_back(plain(a, 32'h00000010));
    send(a);
    wait_empty("drain_after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
